clk_div_ctrl: RTL
=================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the divide-counter and ratio width.
REQ-002 SHALL have parameter DEFAULT_DIV, default 4, giving the divide ratio loaded at reset.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  run request; high = divide, low = stop at period end.
REQ-006 SHALL have port div_req  input  1  ratio-change request, held high until div_ack.
REQ-007 SHALL have port div_val  input  CNT_W  requested ratio N, stable while div_req is high.
REQ-008 SHALL have port div_ack  output  1  one-cycle pulse completing a ratio request.
REQ-009 SHALL have port div_err  output  1  one-cycle pulse coincident with div_ack when the request was rejected.
REQ-010 SHALL have port tick  output  1  one-cycle enable pulse, once per divided period.
REQ-011 SHALL have port div_clk  output  1  registered divided clock.
REQ-012 SHALL have port cnt  output  CNT_W  current phase count.
REQ-013 SHALL have port busy  output  1  high when state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, RUN and DRAIN, plus a separate pend flag holding a latched ratio.
REQ-015 IDLE SHALL hold cnt=0, tick=0, div_clk=0; en=1 moves to RUN on the next edge with cnt=0.
REQ-016 RUN/DRAIN SHALL increment cnt each cycle and wrap to 0 after div_r-1.
REQ-017 tick SHALL be high exactly in the cycle where cnt==div_r-1 and state is RUN or DRAIN.
REQ-018 div_clk SHALL be a flop whose value is 1 when cnt < floor(div_r/2) and 0 otherwise; it never glitches.
REQ-019 en=0 in RUN SHALL move to DRAIN; DRAIN SHALL go to IDLE after the tick cycle; en=1 in DRAIN SHALL return to RUN with no lost cycle.
REQ-020 Valid ratios SHALL be 2..2^CNT_W-1; div_val<2 SHALL give div_ack and div_err one cycle after sampling, with div_r unchanged.
REQ-021 A valid div_req in IDLE SHALL load div_r and pulse div_ack on the next edge.
REQ-022 A valid div_req in RUN/DRAIN SHALL set pend, and div_r SHALL load at the tick edge, with cnt=0 and div_ack in the first cycle of the new period.
REQ-023 div_req SHALL be ignored while pend is set or div_ack is high; a request still high the cycle after div_ack counts as a new request.
REQ-024 Pending change plus DRAIN SHALL apply the ratio and ack at the same tick, then enter IDLE.

Reset
REQ-025 reset low SHALL asynchronously force IDLE, pend=0, div_r=DEFAULT_DIV, and all outputs 0.
REQ-026 Reset mid-request SHALL discard the pending ratio with no div_ack.

Configuration
REQ-027 With CLK_DIV_TICK_CNT_EN defined, a port tick_count output 16 SHALL count tick pulses, wrap 0xFFFF->0 and reset to 0.
REQ-028 Without CLK_DIV_TICK_CNT_EN, the tick_count port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-029 Package clk_div_pkg SHALL hold the state enum (IDLE, RUN, DRAIN), DEFAULT_DIV and TICK_CNT_W=16.
REQ-030 Sub-module clk_div_core SHALL contain the phase counter, tick decode and div_clk flop, driven by div_r and a run enable.

Verification
REQ-031 Release reset, en=1, N=4 -> tick every 4th cycle at cnt=3; div_clk pattern 1,1,0,0; busy=1.
REQ-032 RUN N=4, div_req with div_val=6 at cnt=1 -> period of 4 completes, div_ack when cnt=0 of new period, then period 6 with div_clk 3 high/3 low.
REQ-033 div_req with div_val=1 -> div_ack and div_err one cycle later; period stays 4.
REQ-034 N=4, en=0 at cnt=1 -> tick at cnt=3, then IDLE, busy=0, div_clk=0; en=1 in DRAIN at cnt=2 -> stays running uninterrupted.
REQ-035 reset low while pend is set -> outputs 0 immediately, no div_ack, period 4 after release.
REQ-036 With CLK_DIV_TICK_CNT_EN, N=2 for 65536 ticks -> tick_count returns to 0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and constants for the clock divider controller.
// Contents: controller state enum, default divide ratio, tick counter width.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    localparam int DEFAULT_DIV = 4;
    localparam int TICK_CNT_W  = 16;

endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: phase counter, tick decode and registered divided clock.
// Ports:
//   clk, reset     - system clock, asynchronous active-low reset
//   active         - divider is counting in the current cycle
//   run            - divider will be counting in the next cycle
//   div_r          - ratio in force for the current cycle
//   div_r_nxt      - ratio in force for the next cycle
//   tick           - last cycle of the current period
//   div_clk        - registered divided clock
//   cnt            - current phase count
module clk_div_core #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active,
    input  logic             run,
    input  logic [CNT_W-1:0] div_r,
    input  logic [CNT_W-1:0] div_r_nxt,
    output logic             tick,
    output logic             div_clk,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_clk_q, div_clk_d;

    assign tick = active && (cnt_q == div_r - 1'b1);

    // div_clk is decoded from the next phase and ratio so the flop output
    // always matches the phase shown on cnt in the same cycle.
    always_comb begin
        cnt_d     = (run && active && !tick) ? cnt_q + 1'b1 : '0;
        div_clk_d = run && (cnt_d < (div_r_nxt >> 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            div_clk_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_clk_q <= div_clk_d;
        end
    end

    assign cnt     = cnt_q;
    assign div_clk = div_clk_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable clock divider with run/drain control and
// handshaked ratio changes applied on period boundaries.
// Ports:
//   clk, reset        - system clock, asynchronous active-low reset
//   en                - run request; low stops at the end of the period
//   div_req, div_val  - ratio change request (held until div_ack) and ratio
//   div_ack, div_err  - request completion pulse, rejection flag
//   tick              - one pulse per divided period
//   div_clk           - registered divided clock
//   cnt               - current phase count
//   busy              - controller not idle
//   tick_count        - running tick count, present only with
//                       CLK_DIV_TICK_CNT_EN defined
module clk_div_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             div_req,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic             tick,
    output logic             div_clk,
    output logic [CNT_W-1:0] cnt,
    output logic             busy
`ifdef CLK_DIV_TICK_CNT_EN
    ,
    output logic [clk_div_pkg::TICK_CNT_W-1:0] tick_count
`endif
);

    import clk_div_pkg::*;

    state_e           state_q, state_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic [CNT_W-1:0] div_r_q, div_r_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             req_ok;

    // A request is not sampled while one is pending or while its ack shows.
    assign req_ok = div_req && !pend_q && !ack_q;

    always_comb begin
        state_d    = en ? RUN : ((state_q == IDLE || tick) ? IDLE : DRAIN);
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        div_r_d    = div_r_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        if (req_ok && div_val < CNT_W'(2)) begin
            ack_d = 1'b1;
            err_d = 1'b1;
        end else if (req_ok && state_q == IDLE) begin
            div_r_d = div_val;
            ack_d   = 1'b1;
        end else if (req_ok) begin
            pend_d     = 1'b1;
            pend_val_d = div_val;
        end
        // A latched ratio takes effect on the period boundary.
        if (pend_q && tick) begin
            div_r_d = pend_val_q;
            pend_d  = 1'b0;
            ack_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            div_r_q    <= CNT_W'(DEFAULT_DIV);
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            div_r_q    <= div_r_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    clk_div_core #(.CNT_W(CNT_W)) u_core (
        .clk      (clk),
        .reset    (reset),
        .active   (state_q != IDLE),
        .run      (state_d != IDLE),
        .div_r    (div_r_q),
        .div_r_nxt(div_r_d),
        .tick     (tick),
        .div_clk  (div_clk),
        .cnt      (cnt)
    );

    assign busy    = state_q != IDLE;
    assign div_ack = ack_q;
    assign div_err = err_q;

`ifdef CLK_DIV_TICK_CNT_EN
    logic [TICK_CNT_W-1:0] tick_cnt_q, tick_cnt_d;

    always_comb begin
        tick_cnt_d = tick ? tick_cnt_q + 1'b1 : tick_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tick_cnt_q <= '0;
        else tick_cnt_q <= tick_cnt_d;
    end

    assign tick_count = tick_cnt_q;
`endif

endmodule
